// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract split into STAGES carry-chained segments, one per clock.
// Optional build macro ADDSUB_SATURATE_EN clamps signed-overflowing results to signed max/min.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             carryin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Handshake: an item moves on a rising edge where its valid and the receiver's ready are both 1;
    // the whole pipe advances together whenever the output slot is empty or being drained.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [SEG:0]      seg_sum [STAGES];
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic [WIDTH-1:0]  b_in;
    logic              msb_cin;
    logic              adv;

    always_comb begin
        adv = !valid_q[LAST] || out_ready;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]     = '0;
            b_d[k]     = '0;
            s_d[k]     = '0;
            seg_sum[k] = '0;
        end
        valid_d = '0;
        carry_d = '0;

        // Subtract is A + ~B + ~borrow, so only the B' and cin forming differs from add.
        b_in       = op_sub ? ~input2 : input2;
        seg_sum[0] = {1'b0, input1[SEG-1:0]} + {1'b0, b_in[SEG-1:0]}
                   + {{SEG{1'b0}}, carryin ^ op_sub};
        a_d[0]     = input1;
        b_d[0]     = b_in;
        s_d[0][SEG-1:0] = seg_sum[0][SEG-1:0];
        carry_d[0] = seg_sum[0][SEG];
        valid_d[0] = in_valid;

        for (int k = 1; k < STAGES; k++) begin
            seg_sum[k] = {1'b0, a_q[k-1][k*SEG +: SEG]} + {1'b0, b_q[k-1][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, carry_q[k-1]};
            a_d[k]     = a_q[k-1];
            b_d[k]     = b_q[k-1];
            s_d[k]     = s_q[k-1];
            s_d[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
            carry_d[k] = seg_sum[k][SEG];
            valid_d[k] = valid_q[k-1];
        end

        // Carry into the MSB recovered from the MSB sum bit: c[W-1] = a ^ b' ^ s.
        msb_cin = a_d[LAST][WIDTH-1] ^ b_d[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1];
        ovf_d   = carry_d[LAST] ^ msb_cin;
`ifdef ADDSUB_SATURATE_EN
        if (ovf_d) begin
            s_d[LAST] = a_d[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        zero_d = (s_d[LAST] == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = valid_q[LAST];
    assign sum       = s_q[LAST];
    assign carryout  = carry_q[LAST];
    assign overflow  = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: random and directed ops against a plain-arithmetic model.
module tb_pipelined_addsub;
    localparam int W  = 32;
    localparam int S  = 4;
    localparam int RW = W + 3;
    localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (W - 1));
    localparam longint UMOD = longint'(1) <<< W;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] input1 = '0;
    logic [W-1:0] input2 = '0;
    logic         carryin = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         carryout;
    logic         overflow;
    logic         zero;

    logic [RW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rdy_mode = 0;
    int stall_seen = 0;
    logic          hold_valid = 1'b0;
    logic [RW-1:0] hold_val = '0;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .input1(input1), .input2(input2), .carryin(carryin), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .carryout(carryout), .overflow(overflow), .zero(zero)
    );

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference model: exact integer arithmetic, flags from range tests.
    function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic ci, input logic sb);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sbv = longint'($signed(b));
        longint c = ci ? 64'sd1 : 64'sd0;
        longint ures;
        longint sres;
        logic co, ov;
        logic [W-1:0] s;
        if (!sb) begin
            ures = ua + ub + c;
            sres = sa + sbv + c;
            co   = (ures >= UMOD);
        end else begin
            ures = ua - ub - c;
            sres = sa - sbv - c;
            co   = (ures >= 0);
        end
        s  = ures[W-1:0];
        ov = (sres > SMAX) || (sres < SMIN);
`ifdef ADDSUB_SATURATE_EN
        if (ov) s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return {s, co, ov, (s == '0)};
    endfunction

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb);
        int waited = 0;
        bit done = 0;
        input1 = a; input2 = b; carryin = ci; op_sub = sb; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(a, b, ci, sb));
                acc_cyc = cyc;
                done = 1;
            end else if (++waited > 100) begin
                checks++; errors++;
                $display("FAIL accept_timeout: in_ready got 0 expected 1 within 100 cycles");
                done = 1;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        check("drain_empty", RW'(exp_q.size()), RW'(0));
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return W'($urandom);
        endcase
    endfunction

    // Sink: randomised backpressure when enabled
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready_rule", RW'(in_ready), RW'(!out_valid || out_ready));
            if (hold_valid && out_valid) check("stall_stable", {sum, carryout, overflow, zero}, hold_val);
            hold_valid = out_valid && !out_ready;
            hold_val   = {sum, carryout, overflow, zero};
            if (out_valid && !out_ready) stall_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: got %h expected no result", {sum, carryout, overflow, zero});
                end else begin
                    check("result", {sum, carryout, overflow, zero}, exp_q.pop_front());
                end
            end
        end else begin
            hold_valid = 1'b0;
        end
    end

    initial begin
        int bad;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", RW'(out_valid), RW'(0));
        check("rst_sum", RW'(sum), RW'(0));
        check("rst_flags", RW'({carryout, overflow, zero}), RW'(0));
        check("rst_in_ready", RW'(in_ready), RW'(1));
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Directed ops; first one also measures latency on an idle pipe
        send(32'h5, 32'h3, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("latency", RW'(cyc - acc_cyc), RW'(S));
        drain();
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        send(32'h3, 32'h5, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
        send(32'h0, 32'h0, 1'b1, 1'b1);
        drain();

        // Eight back-to-back ops with a four-cycle output stall
        stall_seen = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_cycles", RW'(stall_seen), RW'(4));

        // Random traffic with random gaps and random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rdy_mode = 0;
        out_ready = 1'b1;
        drain();

        // Reset with three ops in flight
        send(32'h11, 32'h22, 1'b0, 1'b0);
        send(32'h33, 32'h44, 1'b1, 1'b0);
        send(32'h55, 32'h66, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", RW'(out_valid), RW'(0));
        check("midrst_sum", RW'(sum), RW'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check("no_stale_after_reset", RW'(bad), RW'(0));
        check("final_queue_empty", RW'(exp_q.size()), RW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
